// File: rtl/svm_pkg.sv
// Shared SVM types and sizes: feature word, packed feature vector and
// modality tag.
package svm_pkg;

  localparam int NBITS       = 16;
  localparam int F_WIDTH     = 20;
  localparam int LOG_F_WIDTH = $clog2(F_WIDTH);

  typedef logic signed [NBITS-1:0] feat_t;
  typedef feat_t [F_WIDTH-1:0]     feat_vec_t;

  typedef enum logic {
    MOD_VALENCE = 1'b0,
    MOD_AROUSAL = 1'b1
  } modality_e;

endpackage

// File: rtl/svm_feat_quant.sv
// Combinational IN_BITS -> NBITS narrowing of one raw feature word.
// SVM_FEAT_SAT_EN selects signed saturation; otherwise the low bits are kept.
module svm_feat_quant
  import svm_pkg::*;
#(
  parameter int IN_BITS = 24
) (
  input  logic signed [IN_BITS-1:0] raw,
  output feat_t                     q
);

`ifdef SVM_FEAT_SAT_EN
  localparam logic signed [IN_BITS-1:0] SAT_MAX = IN_BITS'(2 ** (NBITS - 1) - 1);
  localparam logic signed [IN_BITS-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (raw > SAT_MAX)      q = SAT_MAX[NBITS-1:0];
    else if (raw < SAT_MIN) q = SAT_MIN[NBITS-1:0];
    else                    q = raw[NBITS-1:0];
  end
`else
  // Upper bits are intentionally discarded; wrap-around is acceptable here.
  logic unused_raw;
  assign unused_raw = ^raw;
  assign q          = raw[NBITS-1:0];
`endif

endmodule

// File: rtl/svm_feature_packer.sv
// Packs F_WIDTH feature words into alternating valence/arousal vectors for SVM
// through a ping-pong buffer. SVM_FEAT_SAT_EN enables input saturation.
module svm_feature_packer
  import svm_pkg::*;
#(
  parameter int IN_BITS = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IN_BITS-1:0] feat_in,
  input  logic                     feat_valid,
  output logic                     feat_ready,
  input  logic                     feat_last,
  output logic [NBITS*F_WIDTH-1:0] in_features,
  output logic                     fin_valid,
  input  logic                     fin_ready,
  output logic                     out_arousal,
  output logic                     len_err
);

  feat_vec_t                buf_q     [2];
  modality_e                buf_mod_q [2];
  logic [LOG_F_WIDTH-1:0]   index_q;
  logic                     wr_ptr_q;
  logic                     rd_ptr_q;
  logic [1:0]               count_q;
  logic [1:0]               count_nxt;
  modality_e                mod_q;
  logic                     feat_ready_q;
  logic                     len_err_q;

  feat_t feat_q;
  logic  xfer, at_end, complete, bad_len, handoff;

  svm_feat_quant #(.IN_BITS(IN_BITS)) u_quant (
    .raw (feat_in),
    .q   (feat_q)
  );

  assign xfer     = feat_valid && feat_ready_q;
  assign at_end   = (index_q == LOG_F_WIDTH'(F_WIDTH - 1));
  assign complete = xfer && feat_last && at_end;
  assign bad_len  = xfer && (feat_last != at_end);
  assign handoff  = fin_valid && fin_ready;

  // NOTE: always_comb assigns a default first so no path leaves count_nxt unassigned (no latch).
  always_comb begin
    count_nxt = count_q;
    if (complete && !handoff)      count_nxt = count_q + 2'd1;
    else if (!complete && handoff) count_nxt = count_q - 2'd1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_q      <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      mod_q        <= MOD_VALENCE;
      feat_ready_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      if (complete) begin
        index_q  <= '0;
        wr_ptr_q <= ~wr_ptr_q;
        mod_q    <= (mod_q == MOD_VALENCE) ? MOD_AROUSAL : MOD_VALENCE;
      end else if (bad_len) begin
        index_q  <= '0;
      end else if (xfer) begin
        index_q  <= index_q + 1'b1;
      end
      if (handoff) rd_ptr_q <= ~rd_ptr_q;
      count_q      <= count_nxt;
      feat_ready_q <= (count_nxt != 2'd2);
      len_err_q    <= bad_len;
    end
  end

  // NOTE: the buffers are not reset; the outputs are gated by fin_valid, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (xfer) buf_q[wr_ptr_q][index_q] <= feat_q;
    if (complete) buf_mod_q[wr_ptr_q] <= mod_q;
  end

  assign feat_ready  = feat_ready_q;
  assign len_err     = len_err_q;
  assign fin_valid   = (count_q != 2'd0);
  assign in_features = fin_valid ? buf_q[rd_ptr_q] : '0;
  assign out_arousal = fin_valid && (buf_mod_q[rd_ptr_q] == MOD_AROUSAL);

endmodule

// File: tb/tb_svm_feature_packer.sv
// Self-checking bench for svm_feature_packer: queue-based vector model,
// per-cycle compare, directed literal checks and a randomized phase.
module tb_svm_feature_packer;
  import svm_pkg::*;

  localparam int IN_BITS = 24;
  localparam int VW      = NBITS * F_WIDTH;

  logic               clk = 1'b0;
  logic               rst;
  logic [IN_BITS-1:0] feat_in;
  logic               feat_valid;
  logic               feat_ready;
  logic               feat_last;
  logic [VW-1:0]      in_features;
  logic               fin_valid;
  logic               fin_ready;
  logic               out_arousal;
  logic               len_err;

  svm_feature_packer #(.IN_BITS(IN_BITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .feat_in     (feat_in),
    .feat_valid  (feat_valid),
    .feat_ready  (feat_ready),
    .feat_last   (feat_last),
    .in_features (in_features),
    .fin_valid   (fin_valid),
    .fin_ready   (fin_ready),
    .out_arousal (out_arousal),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: list of completed vectors awaiting handoff.
  typedef struct {
    logic [VW-1:0] data;
    logic          arousal;
  } exp_t;

  exp_t             m_q[$];
  logic [NBITS-1:0] m_part[$];
  logic             m_mod     = 1'b0;
  logic             m_rdy     = 1'b0;
  logic             m_len_err = 1'b0;
  logic             chk_en    = 1'b0;
  logic             m_take, m_acc;
  exp_t             m_new;

  function automatic logic [NBITS-1:0] q_model(input logic [IN_BITS-1:0] w);
    int v;
    v = int'($signed(w));
`ifdef SVM_FEAT_SAT_EN
    if (v > (2 ** (NBITS - 1)) - 1) v = (2 ** (NBITS - 1)) - 1;
    else if (v < -(2 ** (NBITS - 1))) v = -(2 ** (NBITS - 1));
`endif
    return v[NBITS-1:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_part.delete();
      m_mod     = 1'b0;
      m_rdy     = 1'b0;
      m_len_err = 1'b0;
    end else begin
      m_take    = fin_ready && (m_q.size() != 0);
      m_acc     = feat_valid && m_rdy;
      m_len_err = 1'b0;
      if (m_take) void'(m_q.pop_front());
      if (m_acc) begin
        m_part.push_back(q_model(feat_in));
        if (feat_last && m_part.size() == F_WIDTH) begin
          m_new.data = '0;
          for (int j = 0; j < F_WIDTH; j++) m_new.data[j*NBITS +: NBITS] = m_part[j];
          m_new.arousal = m_mod;
          m_q.push_back(m_new);
          m_mod = ~m_mod;
          m_part.delete();
        end else if (feat_last || m_part.size() == F_WIDTH) begin
          m_len_err = 1'b1;
          m_part.delete();
        end
      end
      m_rdy = (m_q.size() != 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("fin_valid", fin_valid, m_q.size() != 0);
      check("feat_ready", feat_ready, m_rdy);
      check("len_err", len_err, m_len_err);
      if (m_q.size() != 0) begin
        check("in_features", in_features, m_q[0].data);
        check("out_arousal", out_arousal, m_q[0].arousal);
      end
    end
  end

  // Drivers: called at a negedge, return at the negedge after acceptance.
  task automatic send_word(input logic [IN_BITS-1:0] w, input logic last);
    int   t;
    logic acc;
    t = 0;
    feat_in    = w;
    feat_last  = last;
    feat_valid = 1'b1;
    do begin
      acc = feat_ready;
      @(negedge clk);
      t++;
    end while (!acc && t < 2000);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_word: timeout waiting for feat_ready");
    end
    feat_valid = 1'b0;
    feat_last  = 1'b0;
  endtask

  task automatic send_vec(input int n, input logic last_flag, input logic rnd, input int base);
    logic [IN_BITS-1:0] w;
    for (int j = 0; j < n; j++) begin
      w = rnd ? IN_BITS'($urandom) : IN_BITS'(base + j);
      send_word(w, (j == n - 1) ? last_flag : 1'b0);
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic done_rnd;

  initial begin
    rst        = 1'b1;
    feat_in    = '0;
    feat_valid = 1'b0;
    feat_last  = 1'b0;
    fin_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_ready", feat_ready, 1'b0);
    check("reset_in_features", in_features, '0);
    check("reset_len_err", len_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", feat_ready, 1'b1);

    // Basic pair.
    send_vec(20, 1'b1, 1'b0, 1);
    check("basic_valid", fin_valid, 1'b1);
    check("basic_w0", in_features[0 +: NBITS], 16'd1);
    check("basic_w19", in_features[19*NBITS +: NBITS], 16'd20);
    check("basic_arousal", out_arousal, 1'b0);
    send_vec(20, 1'b1, 1'b0, 21);
    check("pair_arousal", out_arousal, 1'b1);
    check("pair_w0", in_features[0 +: NBITS], 16'd21);
    @(negedge clk);

    // Backpressure: two vectors fill both buffers, third stalls.
    fin_ready = 1'b0;
    send_vec(20, 1'b1, 1'b0, 100);
    send_vec(20, 1'b1, 1'b0, 200);
    check("bp_full_ready", feat_ready, 1'b0);
    check("bp_front_arousal", out_arousal, 1'b0);
    check("bp_front_w0", in_features[0 +: NBITS], 16'd100);
    fork
      send_vec(20, 1'b1, 1'b0, 300);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_stall_ready", feat_ready, 1'b0);
        end
        fin_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk);

    // Reset mid-vector discards the partial vector.
    send_vec(10, 1'b0, 1'b0, 400);
    do_reset();
    check("rst_mid_valid", fin_valid, 1'b0);
    check("rst_mid_in_features", in_features, '0);
    @(negedge clk);

    // Length error: feat_last on the 5th word.
    send_vec(5, 1'b1, 1'b0, 40);
    check("lenerr_pulse", len_err, 1'b1);
    check("lenerr_no_valid", fin_valid, 1'b0);
    @(negedge clk);
    check("lenerr_clear", len_err, 1'b0);
    fin_ready = 1'b0;
    send_vec(20, 1'b1, 1'b0, 60);
    check("after_err_arousal", out_arousal, 1'b0);
    check("after_err_w0", in_features[0 +: NBITS], 16'd60);
    check("after_err_w19", in_features[19*NBITS +: NBITS], 16'd79);
    fin_ready = 1'b1;
    @(negedge clk);

    // Saturation / truncation of out-of-range words.
    fin_ready = 1'b0;
    send_word(24'h7FFFFF, 1'b0);
    send_word(24'h800000, 1'b0);
    send_vec(18, 1'b1, 1'b0, 7);
`ifdef SVM_FEAT_SAT_EN
    check("sat_pos", in_features[0 +: NBITS], 16'h7FFF);
    check("sat_neg", in_features[NBITS +: NBITS], 16'h8000);
`else
    check("trunc_pos", in_features[0 +: NBITS], 16'hFFFF);
    check("trunc_neg", in_features[NBITS +: NBITS], 16'h0000);
`endif

    // Simultaneous completion and handoff.
    send_vec(19, 1'b0, 1'b0, 900);
    fin_ready = 1'b1;
    send_word(24'd919, 1'b1);
    fin_ready = 1'b0;
    check("simul_valid", fin_valid, 1'b1);
    check("simul_ready", feat_ready, 1'b1);
    check("simul_w0", in_features[0 +: NBITS], 16'd900);
    check("simul_w19", in_features[19*NBITS +: NBITS], 16'd919);
    fin_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized traffic with random backpressure and occasional length errors.
    done_rnd = 1'b0;
    fork
      begin
        for (int v = 0; v < 16; v++) begin
          case ($urandom_range(0, 5))
            0:       send_vec(int'($urandom_range(1, 19)), 1'b1, 1'b1, 0);
            1:       send_vec(20, 1'b0, 1'b1, 0);
            default: send_vec(20, 1'b1, 1'b1, 0);
          endcase
        end
        done_rnd = 1'b1;
      end
      begin
        while (!done_rnd) begin
          fin_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    fin_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("drain_valid", fin_valid, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/svm_feature_packer.md
Name: svm_feature_packer

Overview:
- Upstream stage of SVM: sits directly before SVM's in_features/fin_valid/fin_ready port.
- Receives one signed feature word per beat from the feature-extraction front end and packs F_WIDTH words into one vector.
- Presents vectors in strict alternation: valence vector, then arousal vector, matching SVM's two-transfer-per-entry protocol.
- Ping-pong double buffer lets capture of the next vector overlap handoff of the current one.

Parameters:
- NBITS, 16, width of one packed feature word (matches `NBITS).
- F_WIDTH, 20, features per vector (matches `F_WIDTH).
- LOG_F_WIDTH, ceilLog2(F_WIDTH), index counter width.
- IN_BITS, 24, width of incoming raw feature word; IN_BITS >= NBITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- feat_in  in  IN_BITS  signed raw feature word
- feat_valid  in  1  feat_in valid
- feat_ready  out  1  packer can accept a word
- feat_last  in  1  marks final word of a vector
- in_features  out  NBITS*F_WIDTH  packed vector to SVM; word j at [j*NBITS +: NBITS]
- fin_valid  out  1  vector valid to SVM
- fin_ready  in  1  SVM accepts vector
- out_arousal  out  1  0 = presented vector is valence, 1 = arousal
- len_err  out  1  one-cycle pulse, vector length mismatch

Behaviour:
- Reset (sync, rst high at posedge): feat_ready=0 during reset and 1 the cycle after; fin_valid=0; in_features=0; out_arousal=0; len_err=0; index=0; wr_ptr=rd_ptr=0; count=0; modality toggle=0 (next captured vector is valence).
- Reset mid-operation discards both buffers and any partial vector; no fin_valid is issued for them.
- Input transfer occurs when feat_valid && feat_ready at posedge. Word is converted to NBITS by truncation to the low NBITS bits, or by saturation per SVM_FEAT_SAT_EN. It is written to buffer[wr_ptr] slot index, and index increments.
- feat_ready = (count != 2). It is registered from state, with no combinational path from fin_ready.
- Completion: accepting a word with index==F_WIDTH-1 and feat_last==1 marks buffer full, tags it with the current modality, toggles modality, flips wr_ptr, sets index=0, and increments count.
- Length error: feat_last==1 at index < F_WIDTH-1, or feat_last==0 at index==F_WIDTH-1:
  - len_err pulses next cycle.
  - The partial vector is dropped and index resets to 0.
  - Modality does not toggle and count does not change.
- Output: fin_valid = (count != 0). in_features and out_arousal are driven from buffer[rd_ptr] and held stable while fin_valid && !fin_ready.
- Handoff when fin_valid && fin_ready: rd_ptr flips and count decrements.
- Latency: last word accepted at edge N gives fin_valid=1 from cycle N+1 when the buffer was empty.
- Simultaneous completion and handoff in one cycle: count is unchanged and both pointers flip.
- At count==2: feat_ready=0 and input stalls. It releases the cycle after a handoff.
- fin_valid, once asserted, is never deasserted without a handoff.

Optional Feature:
- Macro SVM_FEAT_SAT_EN.
- Defined: feat_in is clamped to [-2^(NBITS-1), 2^(NBITS-1)-1] before packing.
- Undefined: the low NBITS bits are taken directly; wrap-around is accepted.
- Irrelevant when IN_BITS==NBITS.

Decomposition:
- Shared package svm_pkg holds:
  - localparams NBITS, F_WIDTH, LOG_F_WIDTH;
  - typedef feat_t (signed [NBITS-1:0]);
  - typedef feat_vec_t (packed array F_WIDTH of feat_t);
  - enum modality_e {MOD_VALENCE, MOD_AROUSAL}.
- One natural sub-module: svm_feat_quant, a combinational IN_BITS->NBITS truncate/saturate that contains the SVM_FEAT_SAT_EN logic.
- Buffer and pointer logic stay in the top module.

Test Plan:
- Basic pair: 20 words 1..20 with feat_last on the 20th, fin_ready=1 → fin_valid one cycle after the last word, in_features[0+:16]=1, [19*16+:16]=20, out_arousal=0. A second vector gives out_arousal=1.
- Backpressure: fin_ready=0 while 3 vectors are sent → feat_ready drops after the 2nd completes. Raising fin_ready yields the vectors in order (valence, arousal, valence) with data stable throughout the stall.
- Length error: feat_last on the 5th word → len_err pulse 1 cycle, no fin_valid, modality unchanged. The next 20-word vector is tagged valence.
- Saturation: feat_in=24'sh7FFFFF and -24'sh800000 → with SVM_FEAT_SAT_EN the words are 16'sh7FFF and 16'sh8000; without it, 16'hFFFF and 16'h0000.
- Reset mid-vector: rst asserted after 10 words → fin_valid=0 and index=0. A following full vector is delivered as valence with correct contents.
- Simultaneous handoff and completion: last word accepted in the same cycle fin_ready accepts the other buffer → count stays 1 and fin_valid stays high with the new vector next cycle.
